prf_mp: RTL
===========

# prf_mp

Parametrised multi-port physical register file with a per-entry ready (scoreboard) bit, same-cycle write-to-read bypass and flush recovery. It is the next generation of the core's PRF. It serves N issue read ports and M writeback broadcast ports. It tracks, per physical register, whether its value has been produced, so issue logic can wake up operands without a separate busy table.

## Interface
Parameters:
- DATA_W, 16, data width per entry
- NUM_PREG, 32, physical register count (power of 2, ≥ 4)
- NUM_RD, 4, read ports (2 per issue lane)
- NUM_WR, 2, writeback ports
- NUM_ALLOC, 3, rename allocation ports per cycle
- PREG_W, $clog2(NUM_PREG), derived, not overridden

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- rd_addr  in  NUM_RD×PREG_W  read addresses
- rd_data  out  NUM_RD×DATA_W  read data, bypassed
- rd_ready  out  NUM_RD  operand-ready flag per read port
- wr_valid  in  NUM_WR  writeback strobe
- wr_addr  in  NUM_WR×PREG_W  writeback destination
- wr_data  in  NUM_WR×DATA_W  writeback value
- alloc_valid  in  NUM_ALLOC  rename allocates a destination preg
- alloc_addr  in  NUM_ALLOC×PREG_W  allocated preg
- flush  in  1  pipeline flush; marks every entry ready

## Operation
- Storage: data[NUM_PREG], ready[NUM_PREG].
- Reset (rst low, async):
  - data[i] = i, zero-extended or truncated to DATA_W.
  - ready[i] = 1 for all i.
  - Outputs then follow the combinational read of the reset contents.
- Entry 0 is hardwired:
  - Writes and allocs to address 0 are ignored.
  - Reads of 0 return data[0] = 0 and ready = 1, with no bypass.
- Write, at posedge:
  - If wr_valid[k] and wr_addr[k] ≠ 0, then data[wr_addr[k]] ← wr_data[k] and ready ← 1.
  - If two ports write the same address in one cycle, the highest-index port wins for data. The entry is ready either way.
- Alloc, at posedge:
  - If alloc_valid[j] and alloc_addr[j] ≠ 0, then ready[alloc_addr[j]] ← 0. Data is unchanged.
  - Alloc and write to the same address in one cycle: alloc wins for ready (entry ends not-ready); the write still updates data.
- Flush, at posedge:
  - All ready bits ← 1; allocs in the same cycle are discarded.
  - Writes in the flush cycle still commit data.
- Read (combinational):
  - rd_data[p] = data[rd_addr[p]] and rd_ready[p] = ready[rd_addr[p]].
  - Bypass: if any valid write this cycle targets rd_addr[p] ≠ 0, output that write's data (same highest-index priority) and rd_ready[p] = 1.
  - Allocs are not bypassed: a read in the alloc cycle sees the pre-alloc ready bit.

## Timing
- Read latency 0, combinational from rd_addr, and from wr_* through the bypass.
- Write, alloc and flush effects are registered and visible from the cycle after the edge. Bypass makes a write visible in its own cycle.
- No handshake and no backpressure: every strobe is accepted every cycle.
- Reset asserted mid-operation: all state returns to the reset values immediately, and in-flight writes and allocs are lost.
- Critical path: wr_addr compare → NUM_WR:1 priority mux → rd_data. Keep the bypass separate from the array read mux.

## Structure
- Package prf_pkg holds:
  - the default parameters, expressed as localparams;
  - the typedef preg_t = logic [PREG_W-1:0] at the default width;
  - the typedef data_t.
- One sub-module, prf_bypass, instantiated once per read port:
  - inputs: the array read value, the address, and all write ports;
  - outputs: the bypassed data and ready;
  - contains the priority compare logic.
- The top level holds the storage array, the ready vector, and the write/alloc/flush update loop. Use generate loops over ports.

## Test plan
- Reset: hold rst low, then release, then read addr 5 → rd_data = 5, rd_ready = 1. Read addr 0 → rd_data = 0, rd_ready = 1.
- Bypass plus commit: drive wr0 = (7, 0xBEEF) while reading 7 → 0xBEEF, ready = 1 in the same cycle. In the next cycle, with no write, reading 7 → 0xBEEF.
- Write conflict: wr0 = (9, 0x1111) and wr1 = (9, 0x2222) in one cycle → bypass and stored value are both 0x2222.
- Scoreboard:
  - Alloc 12 → the next-cycle read of 12 gives ready = 0.
  - wr (12, 0x00AA) → same-cycle ready = 1 and data 0x00AA.
  - Alloc 12 and write 12 in one cycle → next-cycle ready = 0, data = the written value.
- Flush: alloc 3, 4 and 5, then flush together with alloc 6 → next cycle all four read ready = 1. A write to addr 0 with 0xFFFF is ignored; reading 0 → 0.
- Async reset mid-stream: assert rst between edges during writes → outputs revert to the reset contents immediately. After release, previously written entries read their index values.

Source files
------------

// File: rtl/prf_pkg.sv
// Shared defaults and types for the multi-port physical register file.
package prf_pkg;

    localparam int unsigned PRF_DATA_W    = 16;
    localparam int unsigned PRF_NUM_PREG  = 32;
    localparam int unsigned PRF_NUM_RD    = 4;
    localparam int unsigned PRF_NUM_WR    = 2;
    localparam int unsigned PRF_NUM_ALLOC = 3;
    localparam int unsigned PRF_PREG_W    = $clog2(PRF_NUM_PREG);

    typedef logic [PRF_PREG_W-1:0] preg_t;
    typedef logic [PRF_DATA_W-1:0] data_t;

endpackage

// File: rtl/prf_bypass.sv
// Per-read-port writeback bypass: highest-index matching write overrides the array value.
module prf_bypass
    import prf_pkg::*;
#(
    parameter int unsigned DATA_W = PRF_DATA_W,
    parameter int unsigned PREG_W = PRF_PREG_W,
    parameter int unsigned NUM_WR = PRF_NUM_WR
) (
    input  logic [DATA_W-1:0]              arr_data,
    input  logic                           arr_ready,
    input  logic [PREG_W-1:0]              addr,
    input  logic [NUM_WR-1:0]              wr_valid,
    input  logic [NUM_WR-1:0][PREG_W-1:0]  wr_addr,
    input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data,
    output logic [DATA_W-1:0]              byp_data,
    output logic                           byp_ready
);

    logic              hit;
    logic [DATA_W-1:0] hit_data;

    // Later ports overwrite earlier matches, giving highest-index priority.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_valid[k] && (wr_addr[k] == addr) && (addr != '0)) begin
                hit      = 1'b1;
                hit_data = wr_data[k];
            end
        end
    end

    assign byp_data  = hit ? hit_data : arr_data;
    assign byp_ready = hit | arr_ready;

endmodule

// File: rtl/prf_mp.sv
// Multi-port physical register file with per-entry ready bits, write bypass and flush recovery.
module prf_mp
    import prf_pkg::*;
#(
    parameter  int unsigned DATA_W    = PRF_DATA_W,
    parameter  int unsigned NUM_PREG  = PRF_NUM_PREG,
    parameter  int unsigned NUM_RD    = PRF_NUM_RD,
    parameter  int unsigned NUM_WR    = PRF_NUM_WR,
    parameter  int unsigned NUM_ALLOC = PRF_NUM_ALLOC,
    localparam int unsigned PREG_W    = $clog2(NUM_PREG)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_RD-1:0][PREG_W-1:0]     rd_addr,
    output logic [NUM_RD-1:0][DATA_W-1:0]     rd_data,
    output logic [NUM_RD-1:0]                 rd_ready,
    input  logic [NUM_WR-1:0]                 wr_valid,
    input  logic [NUM_WR-1:0][PREG_W-1:0]     wr_addr,
    input  logic [NUM_WR-1:0][DATA_W-1:0]     wr_data,
    input  logic [NUM_ALLOC-1:0]              alloc_valid,
    input  logic [NUM_ALLOC-1:0][PREG_W-1:0]  alloc_addr,
    input  logic                              flush
);

    logic [NUM_PREG-1:0][DATA_W-1:0] mem;
    logic [NUM_PREG-1:0][DATA_W-1:0] mem_nxt;
    logic [NUM_PREG-1:0]             rdy;
    logic [NUM_PREG-1:0]             rdy_nxt;
    logic [NUM_WR-1:0]               wr_live;

    // Entry 0 is never written, so it keeps its reset value of zero and stays ready.
    always_comb begin
        mem_nxt = mem;
        rdy_nxt = rdy;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_valid[k] && (wr_addr[k] != '0)) begin
                mem_nxt[wr_addr[k]] = wr_data[k];
                rdy_nxt[wr_addr[k]] = 1'b1;
            end
        end
        if (flush) begin
            rdy_nxt = '1;
        end else begin
            for (int j = 0; j < NUM_ALLOC; j++) begin
                if (alloc_valid[j] && (alloc_addr[j] != '0)) begin
                    rdy_nxt[alloc_addr[j]] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PREG; i++) begin
                mem[i] <= DATA_W'(i);
            end
            rdy <= '1;
        end else begin
            mem <= mem_nxt;
            rdy <= rdy_nxt;
        end
    end

    // Writes in flight during reset are dropped, so they must not reach the outputs either.
    assign wr_live = wr_valid & {NUM_WR{rst}};

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        prf_bypass #(
            .DATA_W (DATA_W),
            .PREG_W (PREG_W),
            .NUM_WR (NUM_WR)
        ) u_bypass (
            .arr_data  (mem[rd_addr[p]]),
            .arr_ready (rdy[rd_addr[p]]),
            .addr      (rd_addr[p]),
            .wr_valid  (wr_live),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .byp_data  (rd_data[p]),
            .byp_ready (rd_ready[p])
        );
    end

endmodule
